replay_ctrl: RTL
================

// Module: replay_ctrl
// PURPOSE
// Controller sequencing the 129-bit replay buffer on the link transmit path. Assigns a sequence number to each
// outgoing packet, writes it into the buffer, forwards it to the link, and retires buffered entries on ACK.
// Replays every unacknowledged entry, oldest first, on NAK or replay-timer expiry. Sits between the transmit
// source and the link, and owns both buffer ports.
// PARAMETERS
// DATA_W      129   packet/buffer word width
// DEPTH       8     buffer entries (power of 2); ADDR_W = log2(DEPTH)
// SEQ_W       12    sequence-number width, wraps mod 2^SEQ_W
// TIMEOUT     500   replay-timer expiry, in clk cycles
// MAX_REPLAY  3     replays allowed before retrain request
// PORTS
// clk        in   1       clock, all logic on posedge
// reset      in   1       synchronous, active-low reset
// tx_valid   in   1       source has packet
// tx_ready   out  1       packet accepted this cycle when tx_valid&&tx_ready
// tx_data    in   DATA_W  packet payload
// buf_we     out  1       buffer write strobe
// buf_waddr  out  ADDR_W  buffer write address
// buf_wdata  out  DATA_W  buffer write data (= tx_data)
// buf_re     out  1       buffer read strobe; buf_rdata valid next cycle, held until next buf_re
// buf_raddr  out  ADDR_W  buffer read address
// buf_rdata  in   DATA_W  buffer read data
// link_valid out  1       packet on link_data/link_seq
// link_ready in   1       link consumes packet when link_valid&&link_ready
// link_data  out  DATA_W  packet to link
// link_seq   out  SEQ_W   sequence number of link_data
// ack        in   1       ACK pulse for ack_seq
// nak        in   1       NAK pulse for ack_seq (last good seq)
// ack_seq    in   SEQ_W   acknowledged sequence number
// full       out  1       outstanding == DEPTH
// empty      out  1       outstanding == 0
// bad_ack    out  1       1-cycle pulse: ack_seq outside outstanding range
// retrain    out  1       1-cycle pulse: replay limit exceeded
// BEHAVIOUR
// - Reset (reset==0 at posedge): state=NORMAL; next_seq, oldest_seq, wr_ptr, rd_ptr, outstanding, timer, replay_num=0;
//   all strobes, link_valid, tx_ready, bad_ack, retrain=0; empty=1, full=0. Reset mid-replay aborts replay, drops entries.
// - States: NORMAL, REPLAY_RD, REPLAY_TX.
// - NORMAL: tx_ready = link_ready && !full; link_valid = tx_valid && !full; link_data=tx_data, link_seq=next_seq
//   (combinational pass-through, 0-cycle latency). On handshake: buf_we=1, buf_waddr=wr_ptr; wr_ptr++, next_seq++,
//   outstanding++ (all wrap).
// - Timer: counts in NORMAL while !empty; cleared on any ACK/NAK that retires >=1 entry and on replay entry.
//   timer==TIMEOUT-1 -> replay start.
// - ACK/NAK purge (any state): n = (ack_seq - oldest_seq + 1) mod 2^SEQ_W. If n <= outstanding: retire n entries
//   (oldest_seq+=n, rd_ptr+=n, outstanding-=n); if n>0, replay_num=0. Else: no change, bad_ack pulses next cycle.
// - ack && nak same cycle: treated as NAK.
// - NAK in NORMAL after purge: if !empty -> replay start; if empty -> stay NORMAL.
// - Replay start: replay_num++; if replay_num was MAX_REPLAY -> retrain pulse, replay_num=0, replay still runs.
//   rp_ptr=rd_ptr, rp_seq=oldest_seq, go REPLAY_RD. tx_ready=0 throughout replay.
// - REPLAY_RD: buf_re=1, buf_raddr=rp_ptr; next cycle -> REPLAY_TX.
// - REPLAY_TX: link_valid=1, link_data=buf_rdata, link_seq=rp_seq. On link_ready: rp_ptr++, rp_seq++;
//   if rp_ptr+1==wr_ptr -> NORMAL, else -> REPLAY_RD (2 cycles/entry minimum).
// - Purge during replay: if retired range passes rp_ptr, rp_ptr/rp_seq jump to new rd_ptr/oldest_seq (in REPLAY_TX
//   this takes effect after current beat); if empty -> NORMAL. NAK/timeout during replay does not restart it.
// - Simultaneous new write and purge: both applied; outstanding = old + 1 - n.
// CONFIGURATION
// REPLAY_STATS_EN defined: adds outputs stat_replays[15:0] and stat_timeouts[15:0], saturating at 16'hFFFF, cleared by reset;
//   stat_replays increments per replay start, stat_timeouts per timer-triggered start.
// REPLAY_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
// 1. Reset, send 3 packets with link_ready=1 -> link_seq 0,1,2; buf_waddr 0,1,2; outstanding=3; empty=0.
// 2. Send 8 unacked -> full=1, tx_ready=0; ack ack_seq=3 -> 4 retired, full=0, oldest_seq=4.
// 3. 5 outstanding (seq 0-4), nak ack_seq=1 -> retire 0-1; replay link_seq 2,3,4, data matches originals; back to NORMAL.
// 4. 1 outstanding, no ACK -> replay starts at cycle TIMEOUT; 4th consecutive timeout replay pulses retrain.
// 5. ack ack_seq=9 with seq 0-2 outstanding -> bad_ack pulse, state unchanged; ack&&nak same cycle -> NAK path.
// 6. Assert reset low during REPLAY_TX -> next cycle link_valid=0, empty=1, next_seq=0; with REPLAY_STATS_EN stats=0.

Source files
------------

// File: rtl/replay_ctrl.sv
// Replay-buffer controller for the link transmit path: sequences, buffers, forwards and replays packets.
// Optional build macro REPLAY_STATS_EN adds saturating replay/timeout counters (stat_replays, stat_timeouts).
module replay_ctrl #(
  parameter int DATA_W     = 129,
  parameter int DEPTH      = 8,
  parameter int SEQ_W      = 12,
  parameter int TIMEOUT    = 500,
  parameter int MAX_REPLAY = 3,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic              buf_re,
  output logic [ADDR_W-1:0] buf_raddr,
  input  logic [DATA_W-1:0] buf_rdata,
  output logic              link_valid,
  input  logic              link_ready,
  output logic [DATA_W-1:0] link_data,
  output logic [SEQ_W-1:0]  link_seq,
  input  logic              ack,
  input  logic              nak,
  input  logic [SEQ_W-1:0]  ack_seq,
  output logic              full,
  output logic              empty,
  output logic              bad_ack,
  output logic              retrain,
`ifdef REPLAY_STATS_EN
  output logic [15:0]       stat_replays,
  output logic [15:0]       stat_timeouts,
`endif
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] ST_NORMAL    = 2'd0;
  localparam logic [1:0] ST_REPLAY_RD = 2'd1;
  localparam logic [1:0] ST_REPLAY_TX = 2'd2;

  localparam int CNT_W = ADDR_W + 1;
  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int RN_W  = (MAX_REPLAY > 0) ? $clog2(MAX_REPLAY + 1) : 1;

  logic [1:0]        state, state_nx;
  logic [SEQ_W-1:0]  next_seq, oldest_seq, rp_seq, rp_seq_nx, oldest_nx, ack_n, rp_off;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, rp_ptr, rp_ptr_nx, rd_ptr_nx, rp_ptr_inc;
  logic [CNT_W-1:0]  outstanding, outstanding_nx, retire_cnt;
  logic [TMR_W-1:0]  timer, timer_nx;
  logic [RN_W-1:0]   replay_num, replay_num_base, replay_num_nx;
  logic              jump_pend, jump_pend_nx;
  logic              in_normal, wr_fire, purge_req, n_ok, retire, rp_hit;
  logic              timer_hit, start, retrain_hit;

  // Handshakes: a transfer happens on a cycle where valid && ready at posedge clk.
  // In NORMAL the source is passed straight through to the link; during replay the
  // source is stalled (tx_ready=0) and a replayed beat holds link_valid until link_ready.
  assign in_normal  = (state == ST_NORMAL);
  assign full       = (outstanding == CNT_W'(DEPTH));
  assign empty      = (outstanding == '0);
  assign tx_ready   = reset && in_normal && link_ready && !full;
  assign wr_fire    = tx_valid && tx_ready;
  assign buf_we     = wr_fire;
  assign buf_waddr  = wr_ptr;
  assign buf_wdata  = tx_data;
  assign buf_re     = reset && (state == ST_REPLAY_RD);
  assign buf_raddr  = rp_ptr;
  assign link_valid = reset && (in_normal ? (tx_valid && !full) : (state == ST_REPLAY_TX));
  assign link_data  = in_normal ? tx_data : buf_rdata;
  assign link_seq   = in_normal ? next_seq : rp_seq;
  assign state_dbg  = state;

  // ACK/NAK purge: n entries retire, counted from the oldest outstanding sequence number.
  assign purge_req      = ack || nak;
  assign ack_n          = ack_seq - oldest_seq + SEQ_W'(1);
  assign n_ok           = (ack_n <= SEQ_W'(outstanding));
  assign retire         = purge_req && n_ok && (ack_n != '0);
  assign retire_cnt     = retire ? ack_n[CNT_W-1:0] : '0;
  assign outstanding_nx = outstanding + CNT_W'(wr_fire) - retire_cnt;
  assign rd_ptr_nx      = rd_ptr + retire_cnt[ADDR_W-1:0];
  assign oldest_nx      = oldest_seq + (retire ? ack_n : '0);
  assign rp_off         = rp_seq - oldest_seq;
  assign rp_hit         = retire && (rp_off < ack_n);

  assign timer_hit       = in_normal && !empty && (timer == TMR_W'(TIMEOUT - 1));
  assign start           = in_normal && ((nak && n_ok) || timer_hit) && (outstanding_nx != '0);
  assign replay_num_base = retire ? '0 : replay_num;
  assign retrain_hit     = start && (replay_num_base == RN_W'(MAX_REPLAY));
  assign rp_ptr_inc      = rp_ptr + ADDR_W'(1);

  always_comb begin
    replay_num_nx = replay_num_base;
    if (start) replay_num_nx = retrain_hit ? '0 : replay_num_base + RN_W'(1);
  end

  always_comb begin
    timer_nx = timer;
    if (retire || start || empty) timer_nx = '0;
    else if (in_normal)           timer_nx = timer + TMR_W'(1);
  end

  // A purge that overtakes the replay pointer re-aims it; mid-beat the jump waits for the beat to finish.
  always_comb begin
    state_nx     = state;
    rp_ptr_nx    = rp_ptr;
    rp_seq_nx    = rp_seq;
    jump_pend_nx = jump_pend;
    case (state)
      ST_NORMAL: begin
        if (start) begin
          state_nx     = ST_REPLAY_RD;
          rp_ptr_nx    = rd_ptr_nx;
          rp_seq_nx    = oldest_nx;
          jump_pend_nx = 1'b0;
        end
      end
      ST_REPLAY_RD: begin
        if (outstanding_nx == '0) begin
          state_nx = ST_NORMAL;
        end else if (rp_hit) begin
          rp_ptr_nx = rd_ptr_nx;
          rp_seq_nx = oldest_nx;
        end else begin
          state_nx = ST_REPLAY_TX;
        end
      end
      ST_REPLAY_TX: begin
        if (link_ready) begin
          jump_pend_nx = 1'b0;
          if (rp_hit || jump_pend) begin
            rp_ptr_nx = rd_ptr_nx;
            rp_seq_nx = oldest_nx;
            state_nx  = (outstanding_nx == '0) ? ST_NORMAL : ST_REPLAY_RD;
          end else begin
            rp_ptr_nx = rp_ptr_inc;
            rp_seq_nx = rp_seq + SEQ_W'(1);
            state_nx  = (rp_ptr_inc == wr_ptr) ? ST_NORMAL : ST_REPLAY_RD;
          end
        end else if (rp_hit) begin
          jump_pend_nx = 1'b1;
        end
      end
      default: state_nx = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_NORMAL;
      next_seq    <= '0;
      oldest_seq  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rp_ptr      <= '0;
      rp_seq      <= '0;
      outstanding <= '0;
      timer       <= '0;
      replay_num  <= '0;
      jump_pend   <= 1'b0;
      bad_ack     <= 1'b0;
      retrain     <= 1'b0;
    end else begin
      state       <= state_nx;
      next_seq    <= wr_fire ? next_seq + SEQ_W'(1) : next_seq;
      wr_ptr      <= wr_fire ? wr_ptr + ADDR_W'(1) : wr_ptr;
      oldest_seq  <= oldest_nx;
      rd_ptr      <= rd_ptr_nx;
      rp_ptr      <= rp_ptr_nx;
      rp_seq      <= rp_seq_nx;
      outstanding <= outstanding_nx;
      timer       <= timer_nx;
      replay_num  <= replay_num_nx;
      jump_pend   <= jump_pend_nx;
      bad_ack     <= purge_req && !n_ok;
      retrain     <= retrain_hit;
    end
  end

`ifdef REPLAY_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_replays  <= '0;
      stat_timeouts <= '0;
    end else begin
      if (start && (stat_replays != 16'hFFFF))
        stat_replays <= stat_replays + 16'd1;
      if (start && timer_hit && (stat_timeouts != 16'hFFFF))
        stat_timeouts <= stat_timeouts + 16'd1;
    end
  end
`endif

endmodule
